// File: rtl/req_arbiter8.sv
// 8-way request arbiter with hold limit and one-cycle turnaround between owners.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 7 highest).
module req_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] sel_id;
  logic       any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] last_id_q, last_id_d;

  // Later (smaller k) hits overwrite, so the first in search order wins.
  always_comb begin
    sel_id = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req[last_id_q - 3'(k)]) sel_id = last_id_q - 3'(k);
    end
  end
`else
  always_comb begin
    sel_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) sel_id = 3'(i);
    end
  end
`endif

  assign any_req = |req;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_id_d   = last_id_q;
`endif
    unique case (state_q)
      GRANT: begin
        if (done || !req[gnt_id_q]) begin
          state_d     = RELEASE;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else if (hold_cnt_q == HOLD_LIM) begin
          state_d     = RELEASE;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          timeout_d   = 1'b1;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_d       = 8'd1 << sel_id;
          gnt_id_d    = sel_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_id_d   = sel_id;
`endif
        end else begin
          state_d     = IDLE;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed vector bench for req_arbiter8 (default fixed-priority build, MAX_HOLD=4).
module tb_req_arbiter8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  req_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic r, input logic [7:0] rq,
                     input logic d, input logic [7:0] g, input logic [2:0] id,
                     input logic v, input logic t);
    vec_t x;
    x.name = n; x.reset = r; x.req = rq; x.done = d;
    x.gnt = g; x.id = id; x.valid = v; x.tmo = t;
    vecs.push_back(x);
  endtask

  task automatic check(input string n, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic t);
    checks++;
    if (gnt !== g || gnt_id !== id || gnt_valid !== v || timeout !== t) begin
      errors++;
      $display("FAIL %s: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
               n, gnt, gnt_id, gnt_valid, timeout, g, id, v, t);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    @(negedge clk);
    reset = r; req = rq; done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic saw_to;
    reset = 1'b1; req = 8'h00; done = 1'b0;

    add("reset",        1, 8'h00, 0, 8'h00, 0, 0, 0);
    add("grant_14",     0, 8'h14, 0, 8'h10, 4, 1, 0);
    add("hold_ff",      0, 8'hFF, 0, 8'h10, 4, 1, 0);
    add("done_rel",     0, 8'hFF, 1, 8'h00, 0, 0, 0);
    add("regrant_80",   0, 8'hFF, 0, 8'h80, 7, 1, 0);
    add("hold_80",      0, 8'h80, 0, 8'h80, 7, 1, 0);
    add("drop_rel",     0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("idle",         0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("grant_04",     0, 8'h04, 0, 8'h04, 2, 1, 0);
    add("drop_2",       0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("idle2",        0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("to_h0",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("to_h1",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("to_h2",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("to_h3",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("to_pulse",     0, 8'h01, 0, 8'h00, 0, 0, 1);
    add("to_regrant",   0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("co_h1",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("co_h2",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("co_h3",        0, 8'h01, 0, 8'h01, 0, 1, 0);
    add("coincide",     0, 8'h01, 1, 8'h00, 0, 0, 0);
    add("grant_08",     0, 8'h08, 0, 8'h08, 3, 1, 0);
    add("rst_mid",      1, 8'h08, 0, 8'h00, 0, 0, 0);
    add("rst_idle",     0, 8'h00, 0, 8'h00, 0, 0, 0);
    add("fp_81_a",      0, 8'h81, 0, 8'h80, 7, 1, 0);
    add("fp_rel_a",     0, 8'h81, 1, 8'h00, 0, 0, 0);
    add("fp_81_b",      0, 8'h81, 0, 8'h80, 7, 1, 0);
    add("fp_rel_b",     0, 8'h81, 1, 8'h00, 0, 0, 0);
    add("fp_81_c",      0, 8'h81, 0, 8'h80, 7, 1, 0);
    add("low_prio",     1, 8'h00, 0, 8'h00, 0, 0, 0);
    add("grant_06",     0, 8'h06, 0, 8'h04, 2, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].reset, vecs[i].req, vecs[i].done);
      check(vecs[i].name, vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].tmo);
    end

    // Timeout length measured as a free-running sequence with a cycle budget.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h01, 1'b0);
    cnt = 0;
    saw_to = 1'b0;
    for (int c = 0; c < 20 && gnt == 8'h01; c++) begin
      cnt++;
      step(1'b0, 8'h01, 1'b0);
    end
    saw_to = timeout;
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL hold_len: got %0d cycles, want 4", cnt);
    end
    checks++;
    if (saw_to !== 1'b1 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL hold_end: got to=%b gnt=%h, want to=1 gnt=00", saw_to, gnt);
    end
    step(1'b0, 8'h01, 1'b0);
    check("hold_regrant", 8'h01, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
REQ_ARBITER8 -- requirements
Module: req_arbiter8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, legal 2..255: maximum consecutive cycles one requester may hold the grant.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  8  request vector; bit i = requester i.
REQ-005 SHALL have port done  input  1  current owner releases the grant; sampled only in GRANT.
REQ-006 SHALL have port gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 SHALL have port gnt_id  output  3  registered binary index of the owner; 0 when gnt is zero.
REQ-008 SHALL have port gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-009 SHALL have port timeout  output  1  registered one-cycle pulse on a forced release.

Function
REQ-010 SHALL implement states IDLE, GRANT and RELEASE.
REQ-011 In IDLE or RELEASE, if req is non-zero at an edge, SHALL enter GRANT and load gnt, gnt_id and gnt_valid=1 on that same edge; req-to-gnt latency is 1 cycle.
REQ-012 In IDLE or RELEASE with req = 0, SHALL go to IDLE with gnt = 0.
REQ-013 Default selection SHALL be fixed priority: the highest-index set bit of req wins (bit 7 highest, bit 0 lowest).
REQ-014 In GRANT, gnt SHALL remain stable, and changes on other req bits SHALL be ignored.
REQ-015 In GRANT, if done=1 or req[gnt_id]=0 at an edge, SHALL enter RELEASE and clear gnt, gnt_id and gnt_valid on that edge.
REQ-016 RELEASE SHALL last exactly one cycle with gnt = 0, giving a one-cycle turnaround gap between owners.
REQ-017 SHALL keep hold counter hold_cnt (8 bits): 0 on entry to GRANT, +1 each cycle spent in GRANT.
REQ-018 If hold_cnt == MAX_HOLD-1 in GRANT and no release condition holds, SHALL force RELEASE and drive timeout=1 for that one RELEASE cycle.
REQ-019 If a release condition and the timeout condition coincide, SHALL take a normal release with timeout=0.
REQ-020 If the releasing owner still requests in RELEASE, it SHALL compete normally; under fixed priority it may win again.
REQ-021 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req bit was 0 at the grant edge.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0 and last_id=0, overriding all other inputs.
REQ-023 Reset asserted mid-GRANT SHALL drop the grant on that edge without passing through RELEASE and without a timeout pulse.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the priority scheme.
REQ-025 With ARB_ROUND_ROBIN_EN defined, SHALL keep a 3-bit last_id register, updated to gnt_id at each grant edge.
REQ-026 With ARB_ROUND_ROBIN_EN defined, the search order SHALL be descending from (last_id-1) mod 8, wrapping, with last_id lowest. After reset this order is 7..0.
REQ-027 Without ARB_ROUND_ROBIN_EN, SHALL use the fixed priority of REQ-013, and last_id SHALL NOT exist.

Verification
REQ-028 Reset, then req=8'h14 -> 1 cycle later gnt=8'h10, gnt_id=4, gnt_valid=1.
REQ-029 Owner 4 holds, req changes to 8'hFF -> gnt stays 8'h10; done=1 -> next cycle gnt=0 (RELEASE), following cycle gnt=8'h80.
REQ-030 MAX_HOLD=4, req=8'h01 held, done=0 -> gnt=8'h01 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=8'h01 again.
REQ-031 Owner 2 drops req[2] while done=0 -> gnt=0 on the next edge, timeout=0.
REQ-032 reset=1 asserted in GRANT with gnt=8'h08 -> next edge gnt=0, gnt_valid=0, timeout=0, state IDLE.
REQ-033 ARB_ROUND_ROBIN_EN defined, req=8'h81 held, each grant released by done after 1 cycle -> gnt sequence 8'h80, 8'h01, 8'h80, 8'h01; without the macro -> 8'h80 repeatedly.
